// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } md_state_t;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// One iteration of shift-add multiply or restoring divide on {upper,lower}.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] sh;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    always_comb begin
        sh   = {acc[2*WIDTH-2:0], 1'b0};
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // the bit shifted out of the remainder is the 33rd bit of the trial
        diff = {acc[2*WIDTH-1], sh[2*WIDTH-1:WIDTH]} - {1'b0, operand};
        acc_next = acc;
        if (is_div) begin
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
            else
                acc_next = sh;
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: FSM, sign handling, HI/LO regs.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] ZERO_DIV_LO = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [5:0]         cnt;
    logic               neg_q;
    logic               neg_r;
    logic               is_div;
    logic               is_signed;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    assign busy      = (state != IDLE);
    assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
    assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign a_abs     = neg_if(is_signed && a_q[WIDTH-1], a_q);
    assign b_abs     = neg_if(is_signed && b_q[WIDTH-1], b_q);
    assign prod      = neg_q ? -acc : acc;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (mag),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= MD_NOP;
            a_q   <= '0;
            b_q   <= '0;
            mag   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op_code == MD_MTHI) begin
                            hi <= op_a;
                        end else if (op_code == MD_MTLO) begin
                            lo <= op_a;
                        end else if (op_code inside {MD_MULT, MD_MULTU,
                                                     MD_DIV, MD_DIVU}) begin
                            op_q  <= op_code;
                            a_q   <= op_a;
                            b_q   <= op_b;
                            state <= PREP;
                        end
                    end
                end
                PREP: begin
                    neg_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= is_signed && a_q[WIDTH-1];
                    mag   <= is_div ? b_abs : a_abs;
                    acc   <= {{WIDTH{1'b0}}, is_div ? a_abs : b_abs};
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    acc <= acc_next;
                    if (cnt == 6'(ITER_COUNT - 1))
                        state <= FIX;
                    else
                        cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (is_div && b_q == '0) begin
                        lo <= ZERO_DIV_LO;
                        hi <= a_q;
                    end else if (is_div) begin
                        lo <= neg_if(neg_q, acc[WIDTH-1:0]);
                        hi <= neg_if(neg_r, acc[2*WIDTH-1:WIDTH]);
                    end else begin
                        lo <= prod[WIDTH-1:0];
                        hi <= prod[2*WIDTH-1:WIDTH];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = MD_NOP;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input bit inject);
        int bc = 0;
        int dc = 0;
        issue(op, a, b);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 6) begin
                op_valid = 1'b0;
                op_code  = MD_NOP;
            end
            if (busy) bc++;
            if (done) dc++;
            if (k == 20) begin
                check({tag, " hold_hi"}, hi, m_hi);
                check({tag, " hold_lo"}, lo, m_lo);
            end
            if (inject && k == 5) begin
                op_valid = 1'b1;
                op_code  = MD_DIVU;
                op_a     = 32'd1000;
                op_b     = 32'd3;
            end
        end
        check({tag, " busy_cycles"}, 32'(bc), 32'd34);
        check({tag, " early_done"}, 32'(dc), 32'd0);
        @(negedge clk);
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        check({tag, " done_drop"}, {31'b0, done}, 32'd0);
        check({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op_code  = MD_NOP;
        op_a     = '0;
        op_b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        check("rst busy", {31'b0, busy}, 32'd0);
        check("rst done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        run("divu", MD_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 0);
        run("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run("div_pos_neg", MD_DIV, 32'd7, 32'hFFFFFFFE,
            32'h1, 32'hFFFFFFFD, 0);
        run("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 0);
        run("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h80000001,
            32'h7FFFFFFE, 32'h1, 0);
        run("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h1, 0);
        run("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3,
            32'hFFFFFFFF, 32'hFFFFFFFA, 0);
        run("divu_zero", MD_DIVU, 32'h1234, 32'd0,
            32'h1234, 32'hFFFFFFFF, 0);

        @(negedge clk);
        op_valid = 1'b1;
        op_code  = MD_MTHI;
        op_a     = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        check("mthi hi", hi, 32'hCAFEF00D);
        check("mthi lo", lo, 32'hFFFFFFFF);
        check("mthi busy", {31'b0, busy}, 32'd0);
        op_code = MD_MTLO;
        op_a    = 32'h12345678;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = MD_NOP;
        check("mtlo lo", lo, 32'h12345678);
        check("mtlo hi", hi, 32'hCAFEF00D);
        check("mtlo busy", {31'b0, busy}, 32'd0);
        check("mtlo done", {31'b0, done}, 32'd0);
        m_hi = 32'hCAFEF00D;
        m_lo = 32'h12345678;

        run("divu_inject", MD_DIVU, 32'd100, 32'd7, 32'h2, 32'hE, 1);

        issue(3'd7, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        check("op7 busy", {31'b0, busy}, 32'd0);
        check("op7 hi", hi, 32'h2);
        check("op7 lo", lo, 32'hE);

        issue(MD_MULT, 32'd5, 32'd6);
        repeat (11) @(negedge clk);
        check("abort busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        m_hi = 0;
        m_lo = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy)
                check("abort quiet", {30'b0, busy, done}, 32'd0);
        end

        run("multu_small", MD_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
